lcd_access_arbiter: RTL and testbench

LCD_ACCESS_ARBITER -- requirements
Module: lcd_access_arbiter

---
 rtl/lcd_access_arbiter_if.sv | 29 ++
 rtl/lcd_access_arbiter.sv | 163 ++++++++++++++++
 tb/tb_lcd_access_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_access_arbiter_if.sv
// lcd_access_arbiter_if: requester and LCD-writer signals between the display
// clients and the LCD access arbiter. Requester data is packed by index i:
// row [2i+1:2i], col [4i+3:4i], char [8i+7:8i].
interface lcd_access_arbiter_if;
   logic [2:0]  req;
   logic [5:0]  req_row;
   logic [11:0] req_col;
   logic [23:0] req_char;
   logic [2:0]  gnt;
   logic [2:0]  done;
   logic [2:0]  err;
   logic        arb_busy;
   logic        lcd_busy;
   logic        lcd_done;
   logic        lcd_req;
   logic [1:0]  lcd_row;
   logic [3:0]  lcd_col;
   logic [7:0]  lcd_char;

   modport slave (
      input  req, req_row, req_col, req_char, lcd_busy, lcd_done,
      output gnt, done, err, arb_busy, lcd_req, lcd_row, lcd_col, lcd_char
   );

   modport master (
      output req, req_row, req_col, req_char, lcd_busy, lcd_done,
      input  gnt, done, err, arb_busy, lcd_req, lcd_row, lcd_col, lcd_char
   );
endinterface

// File: rtl/lcd_access_arbiter.sv
// lcd_access_arbiter: round-robin arbiter giving three display clients
// (0 = decoder text, 1 = speed status, 2 = mode banner) exclusive access to a
// single LCD character writer.
// Optional macro LCD_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog of
// LCD_TIMEOUT_CYCLES cycles that ends a stuck write with done+err.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no owner; grant the round-robin winner when the writer is free
// ISSUE     | one-cycle lcd_req strobe with latched row/col/char
// WAIT_DONE | waiting for lcd_done (or the watchdog, when built)
module lcd_access_arbiter #(
   parameter int unsigned LCD_TIMEOUT_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   lcd_access_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [2:0]  gnt_q;
   logic [2:0]  done_q;
   logic        lcd_req_q;
   logic [1:0]  lcd_row_q;
   logic [3:0]  lcd_col_q;
   logic [7:0]  lcd_char_q;
   logic [1:0]  last_q;
   logic [1:0]  owner_q;

   logic [1:0]  win_d;
   logic        win_vld_d;
   logic [2:0]  win_onehot_d;
   logic [1:0]  row_d;
   logic [3:0]  col_d;
   logic [7:0]  char_d;

   if (LCD_TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("LCD_TIMEOUT_CYCLES must be at least 1");
   end

`ifdef LCD_ARB_TIMEOUT_EN
   localparam int WD_W = (LCD_TIMEOUT_CYCLES > 1) ? $clog2(LCD_TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(LCD_TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_q;
   logic [2:0]      err_q;
`endif

   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   // Round-robin winner search starting one past the last served requester
   always_comb begin
      logic [1:0] c0;
      logic [1:0] c1;
      logic [1:0] c2;
      c0 = inc3(last_q);
      c1 = inc3(c0);
      c2 = inc3(c1);
      win_vld_d = |bus.req;
      if (bus.req[c0])      win_d = c0;
      else if (bus.req[c1]) win_d = c1;
      else                  win_d = c2;
      win_onehot_d = 3'b001 << win_d;
      case (win_d)
         2'd0:    begin row_d = bus.req_row[1:0]; col_d = bus.req_col[3:0];  char_d = bus.req_char[7:0];   end
         2'd1:    begin row_d = bus.req_row[3:2]; col_d = bus.req_col[7:4];  char_d = bus.req_char[15:8];  end
         default: begin row_d = bus.req_row[5:4]; col_d = bus.req_col[11:8]; char_d = bus.req_char[23:16]; end
      endcase
   end

   // Arbitration FSM with registered grant, strobe, data and completion pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         done_q     <= '0;
         lcd_req_q  <= 1'b0;
         lcd_row_q  <= '0;
         lcd_col_q  <= '0;
         lcd_char_q <= 8'h20;
         last_q     <= 2'd2;
         owner_q    <= 2'd0;
`ifdef LCD_ARB_TIMEOUT_EN
         wd_q       <= '0;
         err_q      <= '0;
`endif
      end else begin
         done_q    <= '0;
         lcd_req_q <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
         err_q     <= '0;
`endif
         case (state_q)
            IDLE: begin
               if (win_vld_d && !bus.lcd_busy) begin
                  state_q    <= ISSUE;
                  gnt_q      <= win_onehot_d;
                  owner_q    <= win_d;
                  lcd_req_q  <= 1'b1;
                  lcd_row_q  <= row_d;
                  lcd_col_q  <= col_d;
                  lcd_char_q <= char_d;
               end
            end
            ISSUE: begin
               // A writer that finishes within the strobe cycle must not
               // leave the arbiter stranded in WAIT_DONE.
               if (bus.lcd_done) begin
                  state_q <= IDLE;
                  done_q  <= gnt_q;
                  gnt_q   <= '0;
                  last_q  <= owner_q;
               end else begin
                  state_q <= WAIT_DONE;
`ifdef LCD_ARB_TIMEOUT_EN
                  wd_q    <= '0;
`endif
               end
            end
            WAIT_DONE: begin
               if (bus.lcd_done) begin
                  state_q <= IDLE;
                  done_q  <= gnt_q;
                  gnt_q   <= '0;
                  last_q  <= owner_q;
`ifdef LCD_ARB_TIMEOUT_EN
               end else if (wd_q == WD_LAST) begin
                  state_q <= IDLE;
                  done_q  <= gnt_q;
                  err_q   <= gnt_q;
                  gnt_q   <= '0;
                  last_q  <= owner_q;
               end else begin
                  wd_q    <= wd_q + 1'b1;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.arb_busy = (state_q != IDLE);
   assign bus.lcd_req  = lcd_req_q;
   assign bus.lcd_row  = lcd_row_q;
   assign bus.lcd_col  = lcd_col_q;
   assign bus.lcd_char = lcd_char_q;
`ifdef LCD_ARB_TIMEOUT_EN
   assign bus.err      = err_q;
`else
   assign bus.err      = '0;
`endif

endmodule

// File: tb/tb_lcd_access_arbiter.sv
// tb_lcd_access_arbiter: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_lcd_access_arbiter;
   localparam int TMO = 16;
`ifdef LCD_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lcd_access_arbiter_if bus();

   lcd_access_arbiter #(.LCD_TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [5:0]  DROW = {2'd3, 2'd2, 2'd1};
   localparam logic [11:0] DCOL = {4'd12, 4'd9, 4'd5};
   localparam logic [23:0] DCHR = {8'h43, 8'h42, 8'h41};
   localparam logic [5:0]  AROW = {2'd0, 2'd1, 2'd2};
   localparam logic [11:0] ACOL = 12'hEDC;
   localparam logic [23:0] ACHR = 24'h7A7B7C;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   function automatic logic [31:0] mk(input logic [2:0] g, input logic [2:0] d, input logic [2:0] e,
                                      input logic b, input logic r, input logic [1:0] row,
                                      input logic [3:0] col, input logic [7:0] ch);
      return {7'd0, g, d, e, b, r, row, col, ch};
   endfunction

   function automatic logic [31:0] outs();
      return mk(bus.gnt, bus.done, bus.err, bus.arb_busy, bus.lcd_req,
                bus.lcd_row, bus.lcd_col, bus.lcd_char);
   endfunction

   localparam logic [31:0] RST_OUT = {7'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 4'd0, 8'h20};

   task automatic set_in(input logic [2:0] r, input logic b, input logic ld, input logic alt);
      bus.req      = r;
      bus.lcd_busy = b;
      bus.lcd_done = ld;
      bus.req_row  = alt ? AROW : DROW;
      bus.req_col  = alt ? ACOL : DCOL;
      bus.req_char = alt ? ACHR : DCHR;
   endtask

   task automatic wait_strobe(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (bus.lcd_req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- reference model (owner / phase view) ----------------
   int         m_owner;   // -1 when nobody owns the writer
   int         m_phase;   // 0 = strobe cycle, k = k-th cycle waiting for done
   int         m_last;
   logic [2:0] m_done, m_err;
   logic [1:0] m_row;
   logic [3:0] m_col;
   logic [7:0] m_ch;

   task automatic m_reset();
      m_owner = -1; m_phase = 0; m_last = 2;
      m_done = '0; m_err = '0;
      m_row = '0; m_col = '0; m_ch = 8'h20;
   endtask

   function automatic logic [31:0] m_outs();
      logic [2:0] g;
      g = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
      return mk(g, m_done, m_err, m_owner >= 0, (m_owner >= 0) && (m_phase == 0), m_row, m_col, m_ch);
   endfunction

   task automatic m_step(input logic [2:0] r, input logic b, input logic ld,
                         input logic [5:0] rw, input logic [11:0] cl, input logic [23:0] ch);
      m_done = '0;
      m_err  = '0;
      if (m_owner < 0) begin
         if (r != 3'b000 && !b) begin
            for (int j = 1; j <= 3; j++) begin
               int idx;
               idx = (m_last + j) % 3;
               if (r[idx]) begin
                  m_owner = idx;
                  break;
               end
            end
            m_phase = 0;
            m_row = rw[2*m_owner +: 2];
            m_col = cl[4*m_owner +: 4];
            m_ch  = ch[8*m_owner +: 8];
         end
      end else if (ld) begin
         m_done  = 3'b001 << m_owner;
         m_last  = m_owner;
         m_owner = -1;
      end else if (TMO_EN && m_phase == TMO) begin
         m_done  = 3'b001 << m_owner;
         m_err   = 3'b001 << m_owner;
         m_last  = m_owner;
         m_owner = -1;
      end else begin
         m_phase++;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [2:0] req;
      logic       busy;
      logic       ldone;
      logic       alt;
      logic [2:0] gnt;
      logic [2:0] done;
      logic       busy_o;
      logic       lreq;
      logic [1:0] row;
      logic [3:0] col;
      logic [7:0] ch;
   } vec_t;

   vec_t tbl [14];

   initial begin : main
      bit ok;
      int cnt;
      bit bad;
      int rr_exp [4];

      //          req    bsy   ldn   alt   gnt    done   busy  lreq  row   col   char
      tbl[0]  = '{3'b001, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b1, 2'd1, 4'd5, 8'h41};
      tbl[1]  = '{3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 3'b000, 1'b1, 1'b0, 2'd1, 4'd5, 8'h41};
      tbl[2]  = '{3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 3'b000, 1'b1, 1'b0, 2'd1, 4'd5, 8'h41};
      tbl[3]  = '{3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 2'd1, 4'd5, 8'h41};
      tbl[4]  = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 2'd1, 4'd5, 8'h41};
      tbl[5]  = '{3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd1, 4'd5, 8'h41};
      tbl[6]  = '{3'b010, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd1, 4'd5, 8'h41};
      tbl[7]  = '{3'b010, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd1, 4'd5, 8'h41};
      tbl[8]  = '{3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 1'b1, 2'd2, 4'd9, 8'h42};
      tbl[9]  = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 2'd2, 4'd9, 8'h42};
      tbl[10] = '{3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2, 4'd9, 8'h42};
      tbl[11] = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2, 4'd9, 8'h42};
      tbl[12] = '{3'b100, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2, 4'd9, 8'h42};
      tbl[13] = '{3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2, 4'd9, 8'h42};

      set_in(3'b000, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_values", outs(), RST_OUT);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         set_in(tbl[i].req, tbl[i].busy, tbl[i].ldone, tbl[i].alt);
         @(negedge clk);
         check($sformatf("vec%0d", i), outs(),
               mk(tbl[i].gnt, tbl[i].done, 3'b000, tbl[i].busy_o, tbl[i].lreq,
                  tbl[i].row, tbl[i].col, tbl[i].ch));
      end

      // Mid-transaction reset: last served is 1, so requester 2 wins.
      set_in(3'b100, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("mr_grant", {29'd0, bus.gnt}, 32'd4);
      set_in(3'b000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("mr_in_wait", {31'd0, bus.arb_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mr_async_reset", outs(), RST_OUT);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.lcd_done = 1'b1;
      @(negedge clk);
      bus.lcd_done = 1'b0;
      check("mr_late_done_ignored", outs(), RST_OUT);

      // Contention with all requests held: 0, 1, 2, 0 after reset.
      rr_exp = '{0, 1, 2, 0};
      bus.req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         wait_strobe(20, ok);
         check($sformatf("rr_strobe%0d", k), {31'd0, ok}, 32'd1);
         check($sformatf("rr_gnt%0d", k), {29'd0, bus.gnt}, 32'(3'b001 << rr_exp[k]));
         bus.lcd_done = 1'b1;
         @(negedge clk);
         bus.lcd_done = 1'b0;
         check($sformatf("rr_done%0d", k), {26'd0, bus.done, bus.gnt}, 32'({3'b001 << rr_exp[k], 3'b000}));
      end
      bus.req = 3'b000;
      @(negedge clk);

      // Writer never answers.
      bus.req = 3'b001;
      wait_strobe(20, ok);
      check("tmo_strobe", {31'd0, ok}, 32'd1);
      bus.req = 3'b000;
`ifdef LCD_ARB_TIMEOUT_EN
      cnt = 0;
      ok  = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.done != 3'b000) begin
            ok = 1'b1;
            break;
         end
         cnt++;
      end
      check("tmo_seen", {31'd0, ok}, 32'd1);
      check("tmo_wait_cycles", 32'(cnt), 32'(TMO));
      check("tmo_done_err", {26'd0, bus.done, bus.err}, {26'd0, 3'b001, 3'b001});
      check("tmo_idle", {31'd0, bus.arb_busy}, 32'd0);
`else
      bad = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (!bus.arb_busy || bus.err != 3'b000 || bus.done != 3'b000) bad = 1'b1;
      end
      check("notmo_holds_wait", {31'd0, bad}, 32'd0);
      bus.lcd_done = 1'b1;
      @(negedge clk);
      bus.lcd_done = 1'b0;
      check("notmo_done_err", {26'd0, bus.done, bus.err}, {26'd0, 3'b001, 3'b000});
`endif

      // Randomized run against the reference model.
      rst_n = 1'b0;
      set_in(3'b000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [2:0]  r;
         logic        b, ld;
         logic [5:0]  rw;
         logic [11:0] cl;
         logic [23:0] ch;
         check($sformatf("rand_cyc%0d", c), outs(), m_outs());
         r  = 3'($urandom_range(0, 7));
         b  = ($urandom_range(0, 3) == 0);
         ld = ($urandom_range(0, 3) == 0);
         rw = 6'($urandom);
         cl = 12'($urandom);
         ch = 24'($urandom);
         bus.req = r; bus.lcd_busy = b; bus.lcd_done = ld;
         bus.req_row = rw; bus.req_col = cl; bus.req_char = ch;
         m_step(r, b, ld, rw, cl, ch);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : guard
      #500000;
      $display("FAIL global_timeout: got no finish required finish before 500000");
      $fatal(1);
   end

endmodule
